// File: rtl/tdm_pkg.sv
// Shared definitions for the 4-channel TDM receive path: channel count,
// alignment-FSM state encoding and slot index constants.
package tdm_pkg;

    localparam int NUM_CH = 4;

    // Frame alignment state: HUNT waits for a start-of-frame, RUN tracks slots.
    typedef enum logic {
        HUNT = 1'b0,
        RUN  = 1'b1
    } state_e;

    typedef logic [1:0] slot_t;

    localparam slot_t SLOT0 = 2'd0;
    localparam slot_t SLOT1 = 2'd1;
    localparam slot_t SLOT2 = 2'd2;
    localparam slot_t SLOT3 = 2'd3;

endpackage : tdm_pkg

// File: rtl/demux_1to4.sv
// 2-bit select to one-hot lane enable, gated by a write strobe. With the
// strobe low no lane is enabled, so the staging registers hold.
module demux_1to4
    import tdm_pkg::*;
(
    input  logic              wr_i,
    input  slot_t             sel_i,
    output logic [NUM_CH-1:0] en_o
);

    // One-hot decode of the selected lane while the strobe is active.
    always_comb begin
        // NOTE: a default assignment before any condition prevents a latch.
        en_o = '0;
        if (wr_i) begin
            en_o[sel_i] = 1'b1;
        end
    end

endmodule : demux_1to4

// File: rtl/tdm_demux_1to4.sv
// Receive end of a 4-channel TDM link. Words arrive one per valid cycle in
// slot order 0..3, slot 0 flagged by sof. Slots 0..2 are staged; when slot 3
// arrives the whole frame is published to ch0..ch3 in one edge. Alignment is
// tracked by a HUNT/RUN machine that pulses sync_err on violations.
module tdm_demux_1to4
    import tdm_pkg::*;
#(
    parameter int W     = 8,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [W-1:0]     din,
    input  logic             din_valid,
    input  logic             sof,
    output logic [W-1:0]     ch0_out,
    output logic [W-1:0]     ch1_out,
    output logic [W-1:0]     ch2_out,
    output logic [W-1:0]     ch3_out,
    output logic             frame_valid,
    output logic             locked,
    output logic [1:0]       slot,
    output logic             sync_err,
    output logic [CNT_W-1:0] frame_cnt
);

    state_e             state_q, state_d;
    slot_t              slot_q, slot_d;
    logic [W-1:0]       stage_q [NUM_CH-1];
    logic [W-1:0]       stage_d [NUM_CH-1];
    logic [W-1:0]       ch_q    [NUM_CH];
    logic [W-1:0]       ch_d    [NUM_CH];
    logic               frame_valid_q, frame_valid_d;
    logic               sync_err_q, sync_err_d;
    logic               locked_q, locked_d;
    logic [CNT_W-1:0]   frame_cnt_q, frame_cnt_d;

    logic               lane_wr;
    slot_t              lane_sel;
    logic [NUM_CH-1:0]  lane_en;

    // A word is written to a lane when it starts a frame (any state) or when
    // it continues an aligned frame in slots 1..3. Slot-0 words without sof
    // and words seen while hunting are never written.
    assign lane_wr  = din_valid & (sof | ((state_q == RUN) && (slot_q != SLOT0)));
    assign lane_sel = sof ? SLOT0 : slot_q;

    demux_1to4 u_lane_dec (
        .wr_i  (lane_wr),
        .sel_i (lane_sel),
        .en_o  (lane_en)
    );

    // Next-state logic for alignment, staging, frame publication and pulses.
    always_comb begin
        state_d       = state_q;
        slot_d        = slot_q;
        stage_d       = stage_q;
        ch_d          = ch_q;
        frame_cnt_d   = frame_cnt_q;
        frame_valid_d = 1'b0;
        sync_err_d    = 1'b0;

        if (din_valid) begin
            if (sof) begin
                // Early sof inside a running frame is an alignment error;
                // the partial frame is discarded and this word restarts it.
                if ((state_q == RUN) && (slot_q != SLOT0)) begin
                    sync_err_d = 1'b1;
                end
                for (int i = 1; i < NUM_CH - 1; i++) begin
                    stage_d[i] = '0;
                end
                state_d = RUN;
                slot_d  = SLOT1;
            end else if (state_q == RUN) begin
                if (slot_q == SLOT0) begin
                    // Missing sof where slot 0 was expected: lose lock.
                    sync_err_d = 1'b1;
                    state_d    = HUNT;
                    slot_d     = SLOT0;
                end else begin
                    // Slot 3 wraps back to slot 0 naturally in two bits.
                    slot_d = slot_q + 2'd1;
                end
            end
        end

        for (int i = 0; i < NUM_CH - 1; i++) begin
            if (lane_en[i]) begin
                stage_d[i] = din;
            end
        end

        // Slot 3 goes straight to the output together with the staged lanes,
        // so a partial frame can never reach ch0..ch3.
        if (lane_en[NUM_CH-1]) begin
            for (int i = 0; i < NUM_CH - 1; i++) begin
                ch_d[i] = stage_q[i];
            end
            ch_d[NUM_CH-1] = din;
            frame_valid_d  = 1'b1;
            frame_cnt_d    = frame_cnt_q + CNT_W'(1);
        end
    end

    assign locked_d = (state_d == RUN);

    // All state and registered outputs, with synchronous reset.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments only.
        if (rst) begin
            state_q       <= HUNT;
            slot_q        <= SLOT0;
            // NOTE: the staging and output registers are reset as well, since
            // a reset must leave the channel outputs at zero.
            stage_q       <= '{default: '0};
            ch_q          <= '{default: '0};
            frame_valid_q <= 1'b0;
            sync_err_q    <= 1'b0;
            locked_q      <= 1'b0;
            frame_cnt_q   <= '0;
        end else begin
            state_q       <= state_d;
            slot_q        <= slot_d;
            stage_q       <= stage_d;
            ch_q          <= ch_d;
            frame_valid_q <= frame_valid_d;
            sync_err_q    <= sync_err_d;
            locked_q      <= locked_d;
            frame_cnt_q   <= frame_cnt_d;
        end
    end

    assign ch0_out     = ch_q[0];
    assign ch1_out     = ch_q[1];
    assign ch2_out     = ch_q[2];
    assign ch3_out     = ch_q[3];
    assign frame_valid = frame_valid_q;
    assign sync_err    = sync_err_q;
    assign locked      = locked_q;
    assign slot        = slot_q;
    assign frame_cnt   = frame_cnt_q;

endmodule : tdm_demux_1to4
